// File: rtl/sram_wbuf_ctrl_if.sv
// CPU-side request/response bundle between the MEM stage and sram_wbuf_ctrl.
interface sram_wbuf_ctrl_if #(
  parameter int unsigned DATA_W = 32
);
  logic              rd_en;
  logic              wr_en;
  logic [31:0]       addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              wb_empty;

  modport master (output rd_en, wr_en, addr, wdata, input rdata, ready, wb_empty);
  modport slave  (input rd_en, wr_en, addr, wdata, output rdata, ready, wb_empty);
endinterface

// File: rtl/sram_wbuf_ctrl.sv
// SRAM controller with a posted-write FIFO: words are split into SRAM_DW beats,
// each held WAIT_CYCLES cycles; reads wait for the FIFO to drain first.
module sram_wbuf_ctrl #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned SRAM_DW     = 16,
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned WAIT_CYCLES = 3,
  parameter int unsigned WB_DEPTH    = 4
) (
  input  logic               clk,
  input  logic               rst,
  sram_wbuf_ctrl_if.slave    cpu,
  inout  wire  [SRAM_DW-1:0] sram_data,
  output logic [ADDR_W-1:0]  sram_addr,
  output logic [4:0]         sram_ctrl
);
  localparam int unsigned BEATS = DATA_W / SRAM_DW;
  localparam int unsigned WCW   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int unsigned BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned PW    = $clog2(WB_DEPTH);

  // {WE_N, CE_N, OE_N, LB_N, UB_N}
  localparam logic [4:0] CTRL_IDLE = 5'b11111;
  localparam logic [4:0] CTRL_WR   = 5'b00100;
  localparam logic [4:0] CTRL_RD   = 5'b10000;

  localparam logic [WCW-1:0] WC_LAST   = WCW'(WAIT_CYCLES - 1);
  localparam logic [BCW-1:0] BEAT_LAST = BCW'(BEATS - 1);

  typedef struct packed {
    logic [ADDR_W-1:0] base;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {IDLE, WR_BEAT, RD_BEAT, DONE} state_t;

  state_t             r_state;
  logic [WCW-1:0]     r_wcnt;
  logic [BCW-1:0]     r_beat;
  wb_entry_t          r_fifo [WB_DEPTH];
  logic [PW:0]        r_wr_ptr;
  logic [PW:0]        r_rd_ptr;
  logic [DATA_W-1:0]  r_rshift;
  logic [DATA_W-1:0]  r_rdata;
  logic               r_rd_live;
  logic               r_ack;
  logic               r_oe;
  logic [SRAM_DW-1:0] r_dout;

  logic               w_empty;
  logic               w_full;
  logic               w_last;
  logic               w_pop;
  logic               w_push;
  logic               w_ready;
  logic [ADDR_W-1:0]  w_req_base;
  wb_entry_t          w_head;
  logic [DATA_W-1:0]  w_rshift_nxt;

  assign w_empty      = (r_wr_ptr == r_rd_ptr);
  assign w_full       = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign w_last       = (r_wcnt == WC_LAST) && (r_beat == BEAT_LAST);
  assign w_pop        = (r_state == WR_BEAT) && w_last;
  // A full FIFO still accepts a write in the cycle its head is popped.
  assign w_push       = cpu.wr_en && !cpu.rd_en && (!w_full || w_pop);
  assign w_req_base   = ADDR_W'(32'(cpu.addr >> 2) * BEATS);
  assign w_head       = r_fifo[r_rd_ptr[PW-1:0]];
  assign w_rshift_nxt = DATA_W'({sram_data, r_rshift} >> SRAM_DW);

  always_comb begin
    w_ready = 1'b1;
    if (cpu.rd_en)      w_ready = (r_state == DONE) && r_ack;
    else if (cpu.wr_en) w_ready = !w_full || w_pop;
  end

  assign cpu.ready    = w_ready;
  assign cpu.rdata    = r_rdata;
  assign cpu.wb_empty = w_empty && (r_state != WR_BEAT);
  assign sram_data    = r_oe ? r_dout : {SRAM_DW{1'bz}};

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr[PW-1:0]] <= '{base: w_req_base, data: cpu.wdata};
  end

  // Beat sequencer; SRAM pins are registered and change only on beat boundaries.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_wcnt    <= '0;
      r_beat    <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_rshift  <= '0;
      r_rdata   <= '0;
      r_rd_live <= 1'b0;
      r_ack     <= 1'b0;
      r_oe      <= 1'b0;
      r_dout    <= '0;
      sram_addr <= '0;
      sram_ctrl <= CTRL_IDLE;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case (r_state)
        IDLE: begin
          r_wcnt <= '0;
          r_beat <= '0;
          if (!w_empty) begin
            r_state   <= WR_BEAT;
            sram_ctrl <= CTRL_WR;
            sram_addr <= w_head.base;
            r_dout    <= w_head.data[SRAM_DW-1:0];
            r_oe      <= 1'b1;
          end else if (cpu.rd_en) begin
            r_state   <= RD_BEAT;
            sram_ctrl <= CTRL_RD;
            sram_addr <= w_req_base;
            r_rd_live <= 1'b1;
          end
        end
        WR_BEAT, RD_BEAT: begin
          if (r_state == RD_BEAT) begin
            if (!cpu.rd_en) r_rd_live <= 1'b0;
            if (r_wcnt == WC_LAST) r_rshift <= w_rshift_nxt;
          end
          if (r_wcnt != WC_LAST) begin
            r_wcnt <= r_wcnt + 1'b1;
          end else begin
            r_wcnt <= '0;
            if (r_beat != BEAT_LAST) begin
              r_beat    <= r_beat + 1'b1;
              sram_addr <= sram_addr + 1'b1;
              r_dout    <= SRAM_DW'(w_head.data >> (SRAM_DW * (32'(r_beat) + 1)));
            end else begin
              r_beat    <= '0;
              sram_ctrl <= CTRL_IDLE;
              r_oe      <= 1'b0;
              if (r_state == RD_BEAT) begin
                r_state <= DONE;
                r_ack   <= r_rd_live && cpu.rd_en;
                if (r_rd_live && cpu.rd_en) r_rdata <= w_rshift_nxt;
              end else begin
                r_state <= IDLE;
              end
            end
          end
        end
        DONE: begin
          r_state   <= IDLE;
          r_ack     <= 1'b0;
          r_rd_live <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sram_wbuf_ctrl.sv
// Self-checking bench for sram_wbuf_ctrl: vector table, directed corner sequences
// and random traffic against a word-level memory model.
module tb_sram_wbuf_ctrl;
  localparam int unsigned AW    = 18;
  localparam int unsigned WC0   = 3;
  localparam int unsigned BEAT0 = 2;
  localparam logic [4:0] C_IDLE = 5'b11111;
  localparam logic [4:0] C_WR   = 5'b00100;
  localparam logic [4:0] C_RD   = 5'b10000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_wbuf_ctrl_if #(.DATA_W(32)) c0 ();
  sram_wbuf_ctrl_if #(.DATA_W(64)) c1 ();
  wire  [15:0]   sd0;
  wire  [15:0]   sd1;
  logic [AW-1:0] sa0;
  logic [AW-1:0] sa1;
  logic [4:0]    sc0;
  logic [4:0]    sc1;

  sram_wbuf_ctrl #(.DATA_W(32), .SRAM_DW(16), .ADDR_W(AW), .WAIT_CYCLES(WC0), .WB_DEPTH(4)) dut0 (
    .clk(clk), .rst(rst), .cpu(c0), .sram_data(sd0), .sram_addr(sa0), .sram_ctrl(sc0));
  sram_wbuf_ctrl #(.DATA_W(64), .SRAM_DW(16), .ADDR_W(AW), .WAIT_CYCLES(1), .WB_DEPTH(4)) dut1 (
    .clk(clk), .rst(rst), .cpu(c1), .sram_data(sd1), .sram_addr(sa1), .sram_ctrl(sc1));

  // Asynchronous SRAM models: drive on read strobes, capture on write strobes.
  logic [15:0] mem0 [0:(1<<AW)-1];
  logic [15:0] mem1 [0:(1<<AW)-1];
  int wr_cycles0 = 0;
  assign sd0 = (sc0[4] && !sc0[3] && !sc0[2]) ? mem0[sa0] : 16'hzzzz;
  assign sd1 = (sc1[4] && !sc1[3] && !sc1[2]) ? mem1[sa1] : 16'hzzzz;
  always @(posedge clk) begin
    if (!sc0[4] && !sc0[3]) begin
      mem0[sa0]  <= sd0;
      wr_cycles0 <= wr_cycles0 + 1;
    end
    if (!sc1[4] && !sc1[3]) mem1[sa1] <= sd1;
  end

  int total = 0;
  int bad   = 0;
  logic [31:0] model [int unsigned];

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_cyc;
  } vec_t;
  vec_t tbl [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Called just after a rising edge; holds the request until ready, then drops it.
  task automatic xact0(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                       output int cyc, output bit to, output logic [31:0] rdo, output logic wbe);
    bit done;
    c0.rd_en = rd; c0.wr_en = wr; c0.addr = a; c0.wdata = d;
    cyc = 0; to = 1'b0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (c0.ready) done = 1'b1;
      else begin
        cyc++;
        if (cyc > 300) begin to = 1'b1; done = 1'b1; end
      end
    end
    rdo = c0.rdata; wbe = c0.wb_empty;
    @(posedge clk); #1;
    c0.rd_en = 1'b0; c0.wr_en = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at t=%0t, want finish", $time);
    $fatal(1);
  end

  initial begin
    int cyc;
    bit to;
    bit done;
    logic [31:0] rdo;
    logic wbe;
    logic [4:0]  ectrl;
    logic [31:0] a;
    logic [31:0] d;
    logic [63:0] d64;
    int unsigned op;
    int unsigned w;
    int cnt_at_rst;

    tbl[0] = '{0, 1, 32'h100,   32'hAAAA5555, 32'h0,        0};
    tbl[1] = '{0, 1, 32'h104,   32'h12345678, 32'h0,        0};
    tbl[2] = '{1, 0, 32'h100,   32'h0,        32'hAAAA5555, -1};
    tbl[3] = '{1, 0, 32'h104,   32'h0,        32'h12345678, 7};
    tbl[4] = '{1, 1, 32'h100,   32'hFFFFFFFF, 32'hAAAA5555, 7};
    tbl[5] = '{1, 0, 32'h100,   32'h0,        32'hAAAA5555, 7};
    tbl[6] = '{0, 1, 32'h103,   32'h0BADF00D, 32'h0,        0};
    tbl[7] = '{1, 0, 32'h102,   32'h0,        32'h0BADF00D, -1};
    tbl[8] = '{0, 1, 32'h80000, 32'h5A5A0F0F, 32'h0,        0};
    tbl[9] = '{1, 0, 32'h0,     32'h0,        32'h5A5A0F0F, -1};

    rst = 1'b0;
    c0.rd_en = 1'b0; c0.wr_en = 1'b0; c0.addr = '0; c0.wdata = '0;
    c1.rd_en = 1'b0; c1.wr_en = 1'b0; c1.addr = '0; c1.wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready",    64'(c0.ready),    64'(1));
    check("rst_wb_empty", 64'(c0.wb_empty), 64'(1));
    check("rst_ctrl",     64'(sc0),         64'(C_IDLE));
    check("rst_addr",     64'(sa0),         64'(0));
    check("rst_rdata",    64'(c0.rdata),    64'(0));
    rst = 1'b1;
    @(posedge clk); #1;

    // Posted write, then the two write beats on the SRAM pins.
    xact0(0, 1, 32'h400, 32'hDEADBEEF, cyc, to, rdo, wbe);
    check("t1_wr_wait", 64'(cyc), 64'(0));
    for (int k = 0; k < 2 + BEAT0 * WC0; k++) begin
      @(negedge clk);
      ectrl = (k == 0 || k == 1 + BEAT0 * WC0) ? C_IDLE : C_WR;
      check("t1_ctrl", 64'(sc0), 64'(ectrl));
      if (ectrl == C_WR) begin
        check("t1_addr", 64'(sa0), (k <= WC0) ? 64'h200 : 64'h201);
        check("t1_data", 64'(sd0), (k <= WC0) ? 64'hBEEF : 64'hDEAD);
      end
    end
    check("t1_wb_empty", 64'(c0.wb_empty), 64'(1));
    @(posedge clk); #1;
    check("t1_mem_lo", 64'(mem0[18'h200]), 64'hBEEF);
    check("t1_mem_hi", 64'(mem0[18'h201]), 64'hDEAD);
    model[32'h100] = 32'hDEADBEEF;

    // Read with empty FIFO: cycle-by-cycle pins and latency.
    c0.rd_en = 1'b1; c0.addr = 32'h400;
    for (int k = 0; k <= BEAT0 * WC0 + 1; k++) begin
      @(negedge clk);
      if (k == 0 || k == BEAT0 * WC0 + 1) check("t2_ctrl", 64'(sc0), 64'(C_IDLE));
      else begin
        check("t2_ctrl", 64'(sc0), 64'(C_RD));
        check("t2_addr", 64'(sa0), (k <= WC0) ? 64'h200 : 64'h201);
      end
      check("t2_ready", 64'(c0.ready), (k == BEAT0 * WC0 + 1) ? 64'(1) : 64'(0));
    end
    check("t2_rdata", 64'(c0.rdata), 64'hDEADBEEF);
    @(posedge clk); #1;
    c0.rd_en = 1'b0;

    for (int i = 0; i < 10; i++) begin
      xact0(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, cyc, to, rdo, wbe);
      check($sformatf("vec%0d_timeout", i), 64'(to), 64'(0));
      if (tbl[i].exp_cyc >= 0) check($sformatf("vec%0d_cycles", i), 64'(cyc), 64'(tbl[i].exp_cyc));
      if (tbl[i].rd) check($sformatf("vec%0d_rdata", i), 64'(rdo), 64'(tbl[i].exp_rdata));
    end
    check("vec_alias_lo", 64'(mem0[0]), 64'h0F0F);
    check("vec_alias_hi", 64'(mem0[1]), 64'h5A5A);
    model[32'h40] = 32'h0BADF00D;

    // Five back-to-back writes into a 4-deep FIFO; the fifth waits for the first pop.
    for (int i = 0; i < 5; i++) begin
      xact0(0, 1, 32'h2000 + 32'(4 * i), 32'h30000000 + 32'(i), cyc, to, rdo, wbe);
      check($sformatf("t3_wr%0d_wait", i), 64'(cyc), (i < 4) ? 64'(0) : 64'(BEAT0 * WC0 + 1 - 4));
    end

    // Read right behind a write: must wait for the whole FIFO to drain.
    xact0(0, 1, 32'h10, 32'h11111111, cyc, to, rdo, wbe);
    check("t4_wr_timeout", 64'(to), 64'(0));
    xact0(1, 0, 32'h10, 32'h0, cyc, to, rdo, wbe);
    check("t4_rdata",    64'(rdo),     64'h11111111);
    check("t4_wb_empty", 64'(wbe),     64'(1));
    check("t4_stalled",  64'(cyc > 7), 64'(1));
    xact0(1, 0, 32'h2010, 32'h0, cyc, to, rdo, wbe);
    check("t4_order", 64'(rdo), 64'h30000004);

    // Random traffic over a small word window against the memory model.
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      xact0(0, 1, (32'h1000 + 32'(i)) << 2, d, cyc, to, rdo, wbe);
      model[32'h1000 + 32'(i)] = d;
    end
    for (int n = 0; n < 120; n++) begin
      op = $urandom_range(0, 3);
      w  = $urandom_range(0, 7);
      a  = ((32'h1000 + w) << 2) | 32'($urandom_range(0, 3));
      d  = $urandom;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      if (op <= 1) begin
        xact0(0, 1, a, d, cyc, to, rdo, wbe);
        check("rnd_wr_timeout", 64'(to), 64'(0));
        model[a >> 2] = d;
      end else begin
        xact0(1, op == 3, a, d, cyc, to, rdo, wbe);
        check("rnd_rdata",   64'(rdo),                          64'(model[a >> 2]));
        check("rnd_rd_lat",  64'(cyc >= int'(BEAT0 * WC0 + 1)), 64'(1));
      end
    end
    xact0(1, 0, 32'h4000, 32'h0, cyc, to, rdo, wbe);
    for (int i = 0; i < 8; i++)
      check("rnd_sram_map", {32'h0, mem0[18'h2000 + 18'(2 * i + 1)], mem0[18'h2000 + 18'(2 * i)]},
            64'(model[32'h1000 + 32'(i)]));

    // Asynchronous reset in the middle of a drain.
    for (int i = 0; i < 3; i++) xact0(0, 1, 32'h800 + 32'(4 * i), 32'hC0DE0000 + 32'(i), cyc, to, rdo, wbe);
    @(negedge clk);
    check("t5_draining", 64'(sc0), 64'(C_WR));
    #2 rst = 1'b0;
    #1;
    check("t5_ctrl_async",     64'(sc0),         64'(C_IDLE));
    check("t5_wb_empty_async", 64'(c0.wb_empty), 64'(1));
    check("t5_ready_async",    64'(c0.ready),    64'(1));
    cnt_at_rst = wr_cycles0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("t5_no_writes", 64'(wr_cycles0), 64'(cnt_at_rst));
    check("t5_wb_empty",  64'(c0.wb_empty), 64'(1));
    check("t5_rdata_clr", 64'(c0.rdata),    64'(0));

    // 64-bit word over a 16-bit SRAM with single-cycle beats.
    d64 = 64'h0123456789ABCDEF;
    c1.wr_en = 1'b1; c1.addr = 32'h8; c1.wdata = d64;
    @(negedge clk);
    check("t6_wr_ready", 64'(c1.ready), 64'(1));
    @(posedge clk); #1;
    c1.wr_en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0 || k == 5) check("t6_ctrl", 64'(sc1), 64'(C_IDLE));
      else begin
        check("t6_ctrl", 64'(sc1), 64'(C_WR));
        check("t6_addr", 64'(sa1), 64'(8 + k - 1));
        check("t6_data", 64'(sd1), 64'(16'(d64 >> (16 * (k - 1)))));
      end
    end
    @(posedge clk); #1;
    c1.rd_en = 1'b1; c1.addr = 32'h8;
    cyc = 0; done = 1'b0;
    while (!done && cyc < 50) begin
      @(negedge clk);
      if (c1.ready) done = 1'b1;
      else cyc++;
    end
    check("t6_rd_latency", 64'(cyc), 64'(5));
    check("t6_rdata", c1.rdata, d64);
    @(posedge clk); #1;
    c1.rd_en = 1'b0;
    check("t6_mem", {mem1[11], mem1[10], mem1[9], mem1[8]}, d64);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
